mc_bus_responder: RTL and testbench

FPGA-side responder for the MCU parallel memory-controller bus (mc_ce/mc_we/mc_oe, 6-bit address, 16-bit data). It synchronizes the asynchronous MCU strobes into clk and decodes each access. Writes go to a configuration register file or the command-FIFO push port; reads return register contents, status, or a word popped from the reply FIFO. It sits between the top-level mc_* pins and the bus-pirate state machine FIFOs.

---
 rtl/mc_bus_responder.sv | 182 ++++++++++++++++++
 tb/tb_mc_bus_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_bus_responder.sv
// MCU parallel-bus responder: synchronizes the asynchronous mc_* strobes into clk and
// decodes each access into config-register, command-FIFO push, reply-FIFO pop or status traffic.
module mc_bus_responder #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter int NUM_CFG       = 7,
  parameter int FIFO_ADDR     = 7,
  parameter int STATUS_ADDR   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mc_ce,
  input  logic                             mc_we,
  input  logic                             mc_oe,
  input  logic [MC_ADD_WIDTH-1:0]          mc_add,
  input  logic [MC_DATA_WIDTH-1:0]         mc_data_in,
  output logic [MC_DATA_WIDTH-1:0]         mc_data_out,
  output logic                             mc_data_oe,
  output logic [NUM_CFG*MC_DATA_WIDTH-1:0] cfg_regs,
  output logic [MC_DATA_WIDTH-1:0]         cmd_data,
  output logic                             cmd_valid,
  input  logic                             cmd_ready,
  input  logic [MC_DATA_WIDTH-1:0]         rpl_data,
  input  logic                             rpl_empty,
  output logic                             rpl_pop
);

  localparam logic [MC_ADD_WIDTH-1:0] CFG_LIMIT = MC_ADD_WIDTH'(NUM_CFG);
  localparam logic [MC_ADD_WIDTH-1:0] FIFO_A    = MC_ADD_WIDTH'(FIFO_ADDR);
  localparam logic [MC_ADD_WIDTH-1:0] STATUS_A  = MC_ADD_WIDTH'(STATUS_ADDR);

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} state_t;

  state_t state_q, state_next;

  // [0],[1] synchronize; [2] holds the previous synced value for edge detection.
  // All reset to idle-high so reset release never looks like a falling edge.
  logic [2:0] ce_sr, we_sr, oe_sr;
  logic       ce_s, we_s, oe_s;
  logic       ce_rise, we_fall, we_rise, oe_fall, oe_rise;

  logic [MC_ADD_WIDTH-1:0]  addr_q;
  logic [MC_DATA_WIDTH-1:0] wdata_q, rdata_q, cmd_data_q;
  logic                     data_oe_q, cmd_valid_q, rpl_pop_q;
  logic                     ovf_q, unf_q, err_q;
  logic [MC_DATA_WIDTH-1:0] cfg_q [NUM_CFG];

  logic wr_enter, rd_enter, wr_commit, set_err;
  logic push, set_ovf, clr_sticky, pop, set_unf;
  logic [MC_DATA_WIDTH-1:0] cfg_rd, status_word, rd_value;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce_sr <= 3'b111;
      we_sr <= 3'b111;
      oe_sr <= 3'b111;
    end else begin
      ce_sr <= {ce_sr[1:0], mc_ce};
      we_sr <= {we_sr[1:0], mc_we};
      oe_sr <= {oe_sr[1:0], mc_oe};
    end
  end

  assign ce_s    = ce_sr[1];
  assign we_s    = we_sr[1];
  assign oe_s    = oe_sr[1];
  assign ce_rise = ~ce_sr[2] &  ce_sr[1];
  assign we_fall =  we_sr[2] & ~we_sr[1];
  assign we_rise = ~we_sr[2] &  we_sr[1];
  assign oe_fall =  oe_sr[2] & ~oe_sr[1];
  assign oe_rise = ~oe_sr[2] &  oe_sr[1];

  always_comb begin
    state_next = state_q;
    wr_enter   = 1'b0;
    rd_enter   = 1'b0;
    wr_commit  = 1'b0;
    set_err    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!ce_s) begin
          if ((we_fall || oe_fall) && !we_s && !oe_s) begin
            set_err = 1'b1;
          end else if (we_fall && oe_s) begin
            state_next = ST_WR;
            wr_enter   = 1'b1;
          end else if (oe_fall && we_s) begin
            state_next = ST_RD;
            rd_enter   = 1'b1;
          end
        end
      end
      ST_WR: begin
        // Chip-enable loss aborts the access before the write can commit.
        if (ce_rise) begin
          state_next = ST_IDLE;
        end else if (we_rise) begin
          state_next = ST_IDLE;
          wr_commit  = 1'b1;
        end
      end
      ST_RD: begin
        if (ce_rise || oe_rise) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign push       = wr_commit && (addr_q == FIFO_A) && cmd_ready;
  assign set_ovf    = wr_commit && (addr_q == FIFO_A) && !cmd_ready;
  assign clr_sticky = wr_commit && (addr_q == STATUS_A);
  assign pop        = rd_enter && (mc_add == FIFO_A) && !rpl_empty;
  assign set_unf    = rd_enter && (mc_add == FIFO_A) && rpl_empty;

  always_comb begin
    cfg_rd = '0;
    for (int i = 0; i < NUM_CFG; i++) begin
      if (mc_add == MC_ADD_WIDTH'(i)) cfg_rd = cfg_q[i];
    end
  end

  always_comb begin
    status_word      = '0;
    status_word[4:0] = {err_q, unf_q, ovf_q, ~rpl_empty, cmd_ready};
  end

  always_comb begin
    rd_value = '0;
    if (mc_add < CFG_LIMIT)          rd_value = cfg_rd;
    else if (mc_add == FIFO_A)       rd_value = rpl_empty ? '0 : rpl_data;
    else if (mc_add == STATUS_A)     rd_value = status_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      data_oe_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= '0;
      rpl_pop_q   <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_next;
      data_oe_q   <= (state_next == ST_RD);
      cmd_valid_q <= push;
      rpl_pop_q   <= pop;
      if (wr_enter) begin
        addr_q  <= mc_add;
        wdata_q <= mc_data_in;
      end
      if (rd_enter) rdata_q <= rd_value;
      if (push) cmd_data_q <= wdata_q;
      // A set in the same cycle as a clear wins.
      ovf_q <= (ovf_q & ~clr_sticky) | set_ovf;
      unf_q <= (unf_q & ~clr_sticky) | set_unf;
      err_q <= (err_q & ~clr_sticky) | set_err;
    end
  end

  for (genvar gi = 0; gi < NUM_CFG; gi++) begin : g_cfg
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cfg_q[gi] <= '0;
      end else if (wr_commit && (addr_q == MC_ADD_WIDTH'(gi))) begin
        cfg_q[gi] <= wdata_q;
      end
    end
    assign cfg_regs[gi*MC_DATA_WIDTH +: MC_DATA_WIDTH] = cfg_q[gi];
  end

  assign mc_data_out = rdata_q;
  assign mc_data_oe  = data_oe_q;
  assign cmd_data    = cmd_data_q;
  assign cmd_valid   = cmd_valid_q;
  assign rpl_pop     = rpl_pop_q;

endmodule

// File: tb/tb_mc_bus_responder.sv
// Scoreboard bench for mc_bus_responder: stimulus pushes expected push/pop/read events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_mc_bus_responder;
  localparam int W  = 16;
  localparam int A  = 6;
  localparam int NC = 7;
  localparam logic [A-1:0] FIFO_A   = 6'd7;
  localparam logic [A-1:0] STATUS_A = 6'd8;

  localparam logic [1:0] K_CMD  = 2'd0;
  localparam logic [1:0] K_POP  = 2'd1;
  localparam logic [1:0] K_READ = 2'd2;

  typedef struct packed {
    logic [1:0]   kind;
    logic [W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              mc_ce = 1'b1, mc_we = 1'b1, mc_oe = 1'b1;
  logic [A-1:0]      mc_add = '0;
  logic [W-1:0]      mc_data_in = '0;
  logic [W-1:0]      mc_data_out;
  logic              mc_data_oe;
  logic [NC*W-1:0]   cfg_regs;
  logic [W-1:0]      cmd_data;
  logic              cmd_valid;
  logic              cmd_ready = 1'b1;
  logic [W-1:0]      rpl_data = '0;
  logic              rpl_empty = 1'b1;
  logic              rpl_pop;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  logic oe_prev = 1'b0;

  always #5 clk = ~clk;

  mc_bus_responder dut (
    .clk(clk), .rst(rst),
    .mc_ce(mc_ce), .mc_we(mc_we), .mc_oe(mc_oe),
    .mc_add(mc_add), .mc_data_in(mc_data_in),
    .mc_data_out(mc_data_out), .mc_data_oe(mc_data_oe),
    .cfg_regs(cfg_regs),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rpl_data(rpl_data), .rpl_empty(rpl_empty), .rpl_pop(rpl_pop)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  task automatic check_evt(input logic [1:0] kind, input logic [W-1:0] data, input string name);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s: unexpected event data %0h, nothing expected", name, data);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || (kind != K_POP && data !== e.data)) begin
        fails++;
        $display("FAIL %s: got kind %0d data %0h expected kind %0d data %0h",
                 name, kind, data, e.kind, e.data);
      end else begin
        $display("[TB] ok   %s data %0h", name, data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (cmd_valid) check_evt(K_CMD, cmd_data, "cmd_push");
      if (rpl_pop) check_evt(K_POP, '0, "rpl_pop");
      if (mc_data_oe && !oe_prev) check_evt(K_READ, mc_data_out, "read_data");
    end
    oe_prev = mc_data_oe;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mc_write(input logic [A-1:0] addr, input logic [W-1:0] data);
    @(negedge clk);
    mc_add = addr; mc_data_in = data; mc_ce = 1'b0;
    idle(3);
    mc_we = 1'b0;
    idle(6);
    mc_we = 1'b1;
    idle(3);
    mc_ce = 1'b1;
    idle(4);
  endtask

  task automatic mc_read(input logic [A-1:0] addr);
    @(negedge clk);
    mc_add = addr; mc_ce = 1'b0;
    idle(3);
    mc_oe = 1'b0;
    idle(8);
    mc_oe = 1'b1;
    idle(3);
    mc_ce = 1'b1;
    idle(4);
    check($sformatf("oe_off_after_read_%0h", addr), 128'(mc_data_oe), 128'(0));
  endtask

  task automatic expect_evt(input logic [1:0] kind, input logic [W-1:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cfg_regs"},    128'(cfg_regs),    128'(0));
    check({tag, "_cmd_data"},    128'(cmd_data),    128'(0));
    check({tag, "_cmd_valid"},   128'(cmd_valid),   128'(0));
    check({tag, "_rpl_pop"},     128'(rpl_pop),     128'(0));
    check({tag, "_mc_data_out"}, 128'(mc_data_out), 128'(0));
    check({tag, "_mc_data_oe"},  128'(mc_data_oe),  128'(0));
  endtask

  initial begin
    idle(3);
    check_reset_outputs("reset");
    rst = 1'b1;
    idle(4);

    // Config writes
    mc_write(6'h00, 16'h00FB);
    mc_write(6'h01, 16'h0004);
    check("cfg0", 128'(cfg_regs[15:0]),  128'h00FB);
    check("cfg1", 128'(cfg_regs[31:16]), 128'h0004);

    // Command push accepted, status clean
    expect_evt(K_CMD, 16'h81FF);
    mc_write(FIFO_A, 16'h81FF);
    expect_evt(K_READ, 16'h0001);
    mc_read(STATUS_A);

    // Command dropped on full FIFO sets ovf, status write clears it
    cmd_ready = 1'b0;
    mc_write(FIFO_A, 16'h08AA);
    expect_evt(K_READ, 16'h0004);
    mc_read(STATUS_A);
    mc_write(STATUS_A, 16'hFFFF);
    expect_evt(K_READ, 16'h0000);
    mc_read(STATUS_A);
    cmd_ready = 1'b1;

    // Reply pop and other read sources
    rpl_data = 16'hABCD; rpl_empty = 1'b0;
    expect_evt(K_POP, '0);
    expect_evt(K_READ, 16'hABCD);
    mc_read(FIFO_A);
    expect_evt(K_READ, 16'h0003);
    mc_read(STATUS_A);
    expect_evt(K_READ, 16'h0004);
    mc_read(6'h01);
    expect_evt(K_READ, 16'h0000);
    mc_read(6'h20);

    // Underflow read
    rpl_empty = 1'b1;
    expect_evt(K_READ, 16'h0000);
    mc_read(FIFO_A);
    expect_evt(K_READ, 16'h0009);
    mc_read(STATUS_A);
    mc_write(STATUS_A, 16'h0000);

    // we and oe falling together sets err
    @(negedge clk);
    mc_add = 6'h02; mc_data_in = 16'h3333; mc_ce = 1'b0;
    idle(3);
    mc_we = 1'b0; mc_oe = 1'b0;
    idle(6);
    mc_we = 1'b1; mc_oe = 1'b1;
    idle(3);
    mc_ce = 1'b1;
    idle(4);
    check("cfg2_after_err", 128'(cfg_regs[47:32]), 128'(0));
    expect_evt(K_READ, 16'h0011);
    mc_read(STATUS_A);
    mc_write(STATUS_A, 16'h0000);

    // Abort: ce rises while we still low
    @(negedge clk);
    mc_add = 6'h02; mc_data_in = 16'h1234; mc_ce = 1'b0;
    idle(3);
    mc_we = 1'b0;
    idle(6);
    mc_ce = 1'b1;
    idle(6);
    mc_we = 1'b1;
    idle(4);
    check("cfg2_after_abort", 128'(cfg_regs[47:32]), 128'(0));

    // we strobe with chip enable high is ignored
    @(negedge clk);
    mc_add = 6'h03; mc_data_in = 16'h5555;
    idle(3);
    mc_we = 1'b0;
    idle(6);
    mc_we = 1'b1;
    idle(4);
    check("cfg3_ce_high", 128'(cfg_regs[63:48]), 128'(0));

    // Reset asserted mid-write
    @(negedge clk);
    mc_add = 6'h04; mc_data_in = 16'h7777; mc_ce = 1'b0;
    idle(3);
    mc_we = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(2);
    check_reset_outputs("midrst");
    mc_we = 1'b1; mc_ce = 1'b1;
    idle(2);
    rst = 1'b1;
    idle(6);
    check_reset_outputs("postrst");
    expect_evt(K_READ, 16'h0001);
    mc_read(STATUS_A);

    idle(10);
    check("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
